// File: rtl/scan_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
// Holds the FSM state encoding and the next-unmasked-code search.
package scan_pkg;

   localparam int SEL_W     = 3;
   localparam int NUM_CODES = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   // Returns {found, code}: the lowest code >= fromCode whose mask bit is clear.
   function automatic logic [SEL_W:0] next_unmasked(input logic [SEL_W:0] fromCode,
                                                   input logic [NUM_CODES-1:0] mask);
      logic             found;
      logic [SEL_W-1:0] code;
      found = 1'b0;
      code  = '0;
      for (int i = 0; i < NUM_CODES; i++) begin
         if (!found && (i >= int'(fromCode)) && !mask[i]) begin
            found = 1'b1;
            code  = i[SEL_W-1:0];
         end
      end
      return {found, code};
   endfunction

endpackage

// File: rtl/decoder3to8.sv
// Combinational 3-to-8 one-hot decoder.
module decoder3to8 (
   input  logic [2:0] i_sel,
   output logic [7:0] o_dec
);

   always_comb begin
      o_dec = 8'h01 << i_sel;
   end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a select code through 0..7 with a programmable dwell and a registered one-hot decode.
// Optional macro SCAN_SKIP_MASK_EN adds a skip_mask input that removes codes from the scan.
module decoder_scan_sequencer
   import scan_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          repeat_en,
   input  logic [DW-1:0] dwell,
`ifdef SCAN_SKIP_MASK_EN
   input  logic [7:0]    skip_mask,
`endif
   output logic [2:0]    sel,
   output logic [7:0]    onehot,
   output logic          step,
   output logic          busy,
   output logic          done
);

   scan_state_t      r_state;
   logic [SEL_W-1:0] r_sel;
   logic [7:0]       r_onehot;
   logic             r_step;
   logic             r_done;
   logic [DW-1:0]    r_cnt;
   logic [DW-1:0]    r_dwell;
   logic [7:0]       r_mask;

   scan_state_t      w_stateNext;
   logic [SEL_W-1:0] w_selNext;
   logic [DW-1:0]    w_cntNext;
   logic [DW-1:0]    w_dwellNext;
   logic [7:0]       w_maskNext;
   logic             w_stepNext;
   logic             w_doneNext;
   logic             w_busyNext;
   logic [DW-1:0]    w_dwellEff;
   logic [7:0]       w_maskIn;
   logic [SEL_W:0]   w_first;
   logic [SEL_W:0]   w_adv;
   logic [SEL_W:0]   w_wrap;
   logic [7:0]       w_decNext;

`ifdef SCAN_SKIP_MASK_EN
   assign w_maskIn = skip_mask;
`else
   assign w_maskIn = 8'h00;
`endif

   assign w_dwellEff = (dwell == '0) ? DW'(1) : dwell;
   assign w_first    = next_unmasked('0, w_maskIn);
   assign w_adv      = next_unmasked({1'b0, r_sel} + 4'd1, r_mask);
   assign w_wrap     = next_unmasked('0, r_mask);

   always_comb begin
      w_stateNext = r_state;
      w_selNext   = r_sel;
      w_cntNext   = r_cnt;
      w_dwellNext = r_dwell;
      w_maskNext  = r_mask;
      w_stepNext  = 1'b0;
      w_doneNext  = 1'b0;
      w_busyNext  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_dwellNext = w_dwellEff;
               w_maskNext  = w_maskIn;
               if (w_first[SEL_W]) begin
                  w_stateNext = SCAN;
                  w_selNext   = w_first[SEL_W-1:0];
                  w_cntNext   = w_dwellEff - DW'(1);
                  w_stepNext  = 1'b1;
                  w_busyNext  = 1'b1;
               end else begin
                  w_stateNext = DONE;
                  w_doneNext  = 1'b1;
               end
            end
         end
         SCAN: begin
            w_busyNext = 1'b1;
            if (r_cnt != '0) begin
               w_cntNext = r_cnt - DW'(1);
            end else if (w_adv[SEL_W]) begin
               w_selNext  = w_adv[SEL_W-1:0];
               w_cntNext  = r_dwell - DW'(1);
               w_stepNext = 1'b1;
            end else if (repeat_en) begin
               // Last unmasked code expired: wrap to the lowest unmasked code.
               w_selNext  = w_wrap[SEL_W-1:0];
               w_cntNext  = r_dwell - DW'(1);
               w_stepNext = 1'b1;
            end else begin
               w_stateNext = DONE;
               w_doneNext  = 1'b1;
               w_busyNext  = 1'b0;
            end
         end
         DONE: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   decoder3to8 u_decoder (
      .i_sel (w_selNext),
      .o_dec (w_decNext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_sel    <= '0;
         r_onehot <= '0;
         r_step   <= 1'b0;
         r_done   <= 1'b0;
         r_cnt    <= '0;
         r_dwell  <= '0;
         r_mask   <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_sel    <= w_selNext;
         r_onehot <= w_busyNext ? w_decNext : 8'h00;
         r_step   <= w_stepNext;
         r_done   <= w_doneNext;
         r_cnt    <= w_cntNext;
         r_dwell  <= w_dwellNext;
         r_mask   <= w_maskNext;
      end
   end

   assign sel    = r_sel;
   assign onehot = r_onehot;
   assign step   = r_step;
   assign busy   = (r_state == SCAN);
   assign done   = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer: vector table plus directed corner sequences.
// Skip-mask sequences are compiled only when SCAN_SKIP_MASK_EN is defined.
module tb_decoder_scan_sequencer;

   typedef struct {
      logic       start;
      logic       rep;
      logic [7:0] dwell;
      logic [2:0] sel;
      logic [7:0] oh;
      logic       step;
      logic       busy;
      logic       done;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic       repeatEn;
   logic [7:0] dwell;
`ifdef SCAN_SKIP_MASK_EN
   logic [7:0] skipMask;
`endif
   logic [2:0] sel;
   logic [7:0] onehot;
   logic       step;
   logic       busy;
   logic       done;

   int checks;
   int failures;
   vec_t vecs[36];

   decoder_scan_sequencer #(.DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .repeat_en (repeatEn),
      .dwell     (dwell),
`ifdef SCAN_SKIP_MASK_EN
      .skip_mask (skipMask),
`endif
      .sel       (sel),
      .onehot    (onehot),
      .step      (step),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs at the current negedge, let one rising edge pass, return at the next negedge.
   task automatic applyStimulus(input logic s, input logic r, input logic [7:0] d);
      start    = s;
      repeatEn = r;
      dwell    = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic chkSel, input logic [2:0] eSel,
                              input logic [7:0] eOh, input logic eStep, input logic eBusy,
                              input logic eDone);
      checks++;
      if ((chkSel && (sel !== eSel)) || (onehot !== eOh) || (step !== eStep) ||
          (busy !== eBusy) || (done !== eDone)) begin
         failures++;
         $display("[TB] FAIL %s: got sel=%0d onehot=%h step=%b busy=%b done=%b, expected sel=%0d onehot=%h step=%b busy=%b done=%b",
                  name, sel, onehot, step, busy, done, eSel, eOh, eStep, eBusy, eDone);
      end
   endtask

   function automatic logic [7:0] ohOf(input int code);
      logic [7:0] one;
      one = 8'h01;
      return one << code;
   endfunction

   initial begin
      logic [2:0] eSel;
      int         codes[4];
      checks   = 0;
      failures = 0;

      // dwell=3 scan with mid-scan start pulse, dwell change and repeat_en wiggle,
      // then start held through DONE relaunching a dwell=0 scan.
      for (int r = 0; r < 36; r++) begin
         vecs[r] = '{start:1'b0, rep:1'b0, dwell:8'd5, sel:3'd0, oh:8'h00,
                     step:1'b0, busy:1'b0, done:1'b0};
      end
      vecs[0].dwell = 8'd3;
      vecs[0].start = 1'b1;
      for (int r = 0; r < 24; r++) begin
         vecs[r].sel  = 3'(r / 3);
         vecs[r].oh   = ohOf(r / 3);
         vecs[r].step = ((r % 3) == 0);
         vecs[r].busy = 1'b1;
         vecs[r].rep  = (r >= 8 && r <= 20);
      end
      vecs[5].start = 1'b1;
      vecs[24].sel  = 3'd7;
      vecs[24].done = 1'b1;
      vecs[25].start = 1'b1;
      vecs[25].dwell = 8'd0;
      vecs[25].sel   = 3'd7;
      for (int r = 26; r < 34; r++) begin
         vecs[r].start = 1'b1;
         vecs[r].dwell = 8'd0;
         vecs[r].sel   = 3'(r - 26);
         vecs[r].oh    = ohOf(r - 26);
         vecs[r].step  = 1'b1;
         vecs[r].busy  = 1'b1;
      end
      vecs[34].sel  = 3'd7;
      vecs[34].done = 1'b1;
      vecs[35].sel  = 3'd7;

      rst      = 1'b1;
      start    = 1'b0;
      repeatEn = 1'b0;
      dwell    = 8'd0;
`ifdef SCAN_SKIP_MASK_EN
      skipMask = 8'h00;
`endif
      #12;
      checkOutput("reset_state", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int r = 0; r < 36; r++) begin
         applyStimulus(vecs[r].start, vecs[r].rep, vecs[r].dwell);
         checkOutput($sformatf("vec%0d", r), 1'b1, vecs[r].sel, vecs[r].oh,
                     vecs[r].step, vecs[r].busy, vecs[r].done);
      end

      // repeat_en=1 with dwell=2 wraps 7->0; dropping it lets the next code-7 expiry finish.
      for (int k = 0; k < 34; k++) begin
         applyStimulus(k == 0, k < 20, 8'd2);
         if (k < 32) begin
            eSel = 3'((k / 2) % 8);
            checkOutput($sformatf("repeat%0d", k), 1'b1, eSel, ohOf(int'(eSel)),
                        (k % 2) == 0, 1'b1, 1'b0);
         end else if (k == 32) begin
            checkOutput("repeat_done", 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1);
         end else begin
            checkOutput("repeat_idle", 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
         end
      end

      // Asynchronous reset in the middle of code 4.
      for (int k = 0; k < 9; k++) begin
         applyStimulus(k == 0, 1'b0, 8'd2);
      end
      checkOutput("pre_reset_code4", 1'b1, 3'd4, 8'h10, 1'b1, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 checkOutput("async_reset", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'd1);
      checkOutput("post_reset_idle", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(k == 0, 1'b0, 8'd1);
         if (k < 8) begin
            checkOutput($sformatf("fresh%0d", k), 1'b1, 3'(k), ohOf(k), 1'b1, 1'b1, 1'b0);
         end else if (k == 8) begin
            checkOutput("fresh_done", 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1);
         end else begin
            checkOutput("fresh_idle", 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
         end
      end

`ifdef SCAN_SKIP_MASK_EN
      // Mask 1010_0101 leaves codes 1,3,4,6; later mask changes must not matter.
      codes = '{1, 3, 4, 6};
      skipMask = 8'b1010_0101;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(k == 0, 1'b0, 8'd1);
         skipMask = 8'h00;
         if (k < 4) begin
            checkOutput($sformatf("mask%0d", k), 1'b1, 3'(codes[k]), ohOf(codes[k]),
                        1'b1, 1'b1, 1'b0);
         end else if (k == 4) begin
            checkOutput("mask_done", 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b1);
         end else begin
            checkOutput("mask_idle", 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0);
         end
      end
      skipMask = 8'hFF;
      applyStimulus(1'b1, 1'b0, 8'd1);
      checkOutput("allmask_done", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'd1);
      checkOutput("allmask_idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
`else
      codes = '{0, 0, 0, 0};
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 3-to-8 decoder stage.
- Steps a 3-bit select code through 0..7, holding each code for a programmable dwell.
- Presents both the select code and its registered one-hot decode, with a start/busy/done handshake.
- Used to scan 8 outputs, such as enables or LED rows, one at a time.

Parameters:
- DW, 8, width of the dwell count input. Maximum dwell is 2^DW-1 cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a scan. Sampled only in IDLE.
- repeat_en  input  1  when high at the end of code 7, wrap to code 0 instead of finishing.
- dwell  input  DW  cycles each code is held. Latched on start. A value of 0 is treated as 1.
- sel  output  3  current select code.
- onehot  output  8  registered decode of sel while busy. 8'h00 otherwise.
- step  output  1  one-cycle pulse on each cycle a new code is first presented.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse after the final code's dwell expires.

Behaviour:
- Reset is asynchronous, active-high. It forces state IDLE and drives sel=0, onehot=0, step=0, busy=0, done=0. The dwell counter and dwell latch clear to 0.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at edge E0:
  - After E0: state=SCAN, busy=1, sel=0, onehot=8'h01, step=1.
  - The latched dwell becomes D = max(dwell,1). The counter loads D-1.
- SCAN:
  - The counter decrements each cycle. step=0 except on code-entry cycles.
  - When the counter is 0 and sel<7: sel increments, onehot shifts left by 1, step=1, and the counter reloads D-1.
  - When the counter is 0 and sel=7 with repeat_en=1: sel=0, onehot=8'h01, step=1, and the scan continues.
  - When the counter is 0 and sel=7 with repeat_en=0: go to DONE. busy=0, onehot=0, done=1. sel holds at 7.
- DONE: lasts exactly one cycle, then IDLE with done=0. A start asserted in the DONE cycle is ignored.
- Timing:
  - Each code is visible for exactly D cycles.
  - A non-repeating scan keeps busy high for exactly 8*D cycles.
  - done rises on the cycle after the final code.
- start while busy or in DONE is ignored. A held start relaunches on the first IDLE edge.
- dwell and repeat_en changes mid-scan:
  - dwell changes have no effect until the next start.
  - repeat_en is sampled only at the code-7 expiry.
- Invariants:
  - onehot is always 0 or exactly one bit set.
  - onehot[sel]=1 whenever busy=1.
- Reset mid-scan: outputs go to their reset values immediately, without waiting for a clock edge. No done pulse is produced.

Optional Feature:
- Macro: SCAN_SKIP_MASK_EN.
- When defined:
  - Adds input skip_mask [7:0], latched on start.
  - Codes whose mask bit is 1 are never presented. Advance goes to the next unmasked code in ascending order.
  - Wrap under repeat_en goes to the lowest unmasked code.
  - If all 8 bits are set, the block goes IDLE to DONE directly. busy never rises, and done pulses on the cycle after E0.
  - Busy length becomes N*D, where N is the number of unmasked codes.
- When undefined: the port is absent and all 8 codes are scanned.

Decomposition:
- Shared package scan_pkg holds:
  - State enum (IDLE=2'd0, SCAN=2'd1, DONE=2'd2).
  - SEL_W=3 and NUM_CODES=8.
  - A function returning the next unmasked code.
- Natural sub-module: the existing decoder3to8, instantiated combinationally on the next-sel value. Its output feeds the onehot register, gated to 0 when not busy.

Test Plan:
- Reset while idle, then start=1 for one cycle with dwell=3: sel steps 0..7, each for 3 cycles. onehot goes 01,02,..,80. busy is high 24 cycles. step pulses 8 times. done pulses once, one cycle after busy falls.
- dwell=0, then start: behaves as dwell=1. onehot changes every cycle and busy is high 8 cycles.
- repeat_en=1 with dwell=2, run 20 cycles: sel sequence 0,0,1,1,..,7,7,0,0,1,1. No done pulse. Then drop repeat_en: done follows the next code-7 expiry.
- start pulsed at cycle 5 of a scan, and start held through DONE: both ignored. A held start relaunches the scan on the first IDLE edge.
- rst asserted asynchronously mid-code 4: all outputs go to 0 before the next clk edge. After release, the block is IDLE and a fresh start scans from code 0.
- With SCAN_SKIP_MASK_EN:
  - skip_mask=8'b1010_0101, dwell=1: onehot sequence is 02,08,10,40. busy is high 4 cycles.
  - skip_mask=8'hFF: done pulses one cycle after start and busy stays 0.
